// File: rtl/scancode_pkg.sv
// Shared PS/2 Set-2 constants, key indices and encoder FSM states.
// Imported by the scan code encoder and by the matching key-flag decoder.
package scancode_pkg;

  localparam int NUM_KEYS = 4;

  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ONE   = 8'h16;
  localparam logic [7:0] SC_TWO   = 8'h1E;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  localparam logic [1:0] KEY_ENTER = 2'd0;
  localparam logic [1:0] KEY_SPACE = 2'd1;
  localparam logic [1:0] KEY_ONE   = 2'd2;
  localparam logic [1:0] KEY_TWO   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    CODE   = 2'd2
  } enc_state_e;

  function automatic logic [7:0] key_code(input logic [1:0] idx);
    logic [7:0] code;
    case (idx)
      KEY_ENTER: code = SC_ENTER;
      KEY_SPACE: code = SC_SPACE;
      KEY_ONE:   code = SC_ONE;
      default:   code = SC_TWO;
    endcase
    return code;
  endfunction

  // Lowest set bit wins; callers only use the result when some bit is set.
  function automatic logic [1:0] first_dirty(input logic [3:0] dirty);
    logic [1:0] idx;
    if (dirty[0])      idx = KEY_ENTER;
    else if (dirty[1]) idx = KEY_SPACE;
    else if (dirty[2]) idx = KEY_ONE;
    else               idx = KEY_TWO;
    return idx;
  endfunction

endpackage

// File: rtl/scancode_typematic_timer.sv
// Typematic delay/period counter with a sticky "repeat due" flag.
// Only instantiated when SCANCODE_TYPEMATIC_EN is defined.
module typematic_timer #(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_delay,
  input  logic start_period,
  input  logic cancel,
  input  logic consume,
  output logic pending
);

  // Thresholds are two short of the nominal interval so that, after the
  // IDLE selection cycle and the CODE byte cycle, consecutive make transfers
  // land exactly REPEAT_DELAY / REPEAT_PERIOD cycles apart.
  localparam logic [31:0] DELAY_THR  = 32'((REPEAT_DELAY  > 2) ? REPEAT_DELAY  - 2 : 0);
  localparam logic [31:0] PERIOD_THR = 32'((REPEAT_PERIOD > 2) ? REPEAT_PERIOD - 2 : 0);

  logic [31:0] cnt_q, cnt_d;
  logic        active_q, active_d;
  logic        period_q, period_d;
  logic [31:0] thr;

  assign thr     = period_q ? PERIOD_THR : DELAY_THR;
  assign pending = active_q && (cnt_q >= thr);

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    period_d = period_q;
    if (start_delay || start_period) begin
      cnt_d    = '0;
      active_d = 1'b1;
      period_d = start_period;
    end else if (cancel || consume) begin
      active_d = 1'b0;
    end else if (active_q && !pending) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      period_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/scancode_encoder.sv
// Per-key level to PS/2 Set-2 make/break byte encoder with ready/valid output.
// Define SCANCODE_TYPEMATIC_EN to add typematic repeat of the last made key.
module scancode_encoder
  import scancode_pkg::*;
#(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key_state,
  input  logic       tx_ready,
  output logic [7:0] scan_code,
  output logic       scan_code_ready,
  output logic       busy
);

  enc_state_e  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        make_q, make_d;
  logic        rpt_q, rpt_d;
  logic [7:0]  code_q, code_d;
  logic [3:0]  reported_q, reported_d;

  logic [3:0]  dirty;
  logic [1:0]  sel_idx;
  logic        repeat_pending;
  logic [1:0]  rep_key;
  logic        rpt_select;

  assign dirty           = key_state ^ reported_q;
  assign sel_idx         = first_dirty(dirty);
  assign scan_code       = code_q;
  assign scan_code_ready = (state_q != IDLE);
  assign busy            = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    make_d     = make_q;
    rpt_d      = rpt_q;
    code_d     = code_q;
    reported_d = reported_q;
    rpt_select = 1'b0;
    case (state_q)
      IDLE: begin
        if (|dirty) begin
          idx_d  = sel_idx;
          make_d = key_state[sel_idx];
          rpt_d  = 1'b0;
          if (key_state[sel_idx]) begin
            state_d = CODE;
            code_d  = key_code(sel_idx);
          end else begin
            state_d = PREFIX;
            code_d  = SC_BREAK;
          end
        end else if (repeat_pending) begin
          idx_d      = rep_key;
          make_d     = 1'b1;
          rpt_d      = 1'b1;
          state_d    = CODE;
          code_d     = key_code(rep_key);
          rpt_select = 1'b1;
        end
      end
      PREFIX: begin
        if (tx_ready) begin
          state_d = CODE;
          code_d  = key_code(idx_q);
        end
      end
      CODE: begin
        if (tx_ready) begin
          state_d = IDLE;
          // A repeat only re-sends a held key, so the reported levels stay put.
          if (!rpt_q) reported_d[idx_q] = make_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      make_q     <= 1'b0;
      rpt_q      <= 1'b0;
      code_q     <= 8'h00;
      reported_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      make_q     <= make_d;
      rpt_q      <= rpt_d;
      code_q     <= code_d;
      reported_q <= reported_d;
    end
  end

`ifdef SCANCODE_TYPEMATIC_EN
  logic [1:0] rep_key_q, rep_key_d;
  logic       code_xfer;
  logic       make_xfer;
  logic       rpt_xfer;

  assign code_xfer = (state_q == CODE) && tx_ready;
  assign make_xfer = code_xfer && make_q && !rpt_q;
  assign rpt_xfer  = code_xfer && rpt_q;
  assign rep_key   = rep_key_q;

  always_comb begin
    rep_key_d = rep_key_q;
    if (make_xfer) rep_key_d = idx_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rep_key_q <= '0;
    else          rep_key_q <= rep_key_d;
  end

  // Releasing the rep key covers both cancel cases, since its break can
  // only be selected once its level is low.
  typematic_timer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_delay (make_xfer),
    .start_period(rpt_xfer),
    .cancel      (!key_state[rep_key_q]),
    .consume     (rpt_select),
    .pending     (repeat_pending)
  );
`else
  assign repeat_pending = 1'b0;
  assign rep_key        = 2'd0;
`endif

endmodule

// File: tb/tb_scancode_encoder.sv
// Scoreboard bench for scancode_encoder: directed key patterns push expected
// bytes (with their expected cycle) and a monitor checks every transfer.
module tb_scancode_encoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] key_state = 4'b0000;
  logic       tx_ready = 1'b1;
  logic [7:0] scan_code;
  logic       scan_code_ready;
  logic       busy;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] code;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  logic       hold_pending = 1'b0;
  logic [7:0] held_code = 8'h00;

  scancode_encoder #(
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .key_state      (key_state),
    .tx_ready       (tx_ready),
    .scan_code      (scan_code),
    .scan_code_ready(scan_code_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] keys, input logic rdy);
    key_state = keys;
    tx_ready  = rdy;
  endtask

  task automatic expect_byte(input logic [7:0] code, input int at_cyc);
    exp_t x;
    x.code = code;
    x.cyc  = at_cyc;
    exp_q.push_back(x);
  endtask

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares each transfer against the scoreboard and checks that a
  // stalled byte stays put until it is accepted.
  always @(negedge clk) begin
    if (reset_n) begin
      if (hold_pending) begin
        checks++;
        if (!(scan_code_ready === 1'b1 && scan_code === held_code)) begin
          failures++;
          $display("[TB] FAIL hold_stable: got ready=%b code=%h expected ready=1 code=%h (cycle %0d)",
                   scan_code_ready, scan_code, held_code, cyc);
        end
      end
      hold_pending = scan_code_ready && !tx_ready;
      held_code    = scan_code;
      if (scan_code_ready && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_byte: got %h expected none (cycle %0d)", scan_code, cyc);
        end else begin
          e = exp_q.pop_front();
          if (scan_code !== e.code || (e.cyc >= 0 && cyc != e.cyc)) begin
            failures++;
            $display("[TB] FAIL byte: got %h at cycle %0d expected %h at cycle %0d",
                     scan_code, cyc, e.code, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;

    // Reset with all keys held: outputs clear, then four makes in index order.
    apply_stimulus(4'b1111, 1'b1);
    tick(3);
    check_output("rst_code", scan_code, 8'h00);
    check_output("rst_ready", {7'd0, scan_code_ready}, 8'h00);
    check_output("rst_busy", {7'd0, busy}, 8'h00);
    c = cyc;
    expect_byte(8'h5A, c + 1);
    expect_byte(8'h29, c + 3);
    expect_byte(8'h16, c + 5);
    expect_byte(8'h1E, c + 7);
    reset_n = 1'b1;
    tick(2);
    check_output("idle_gap_busy", {7'd0, busy}, 8'h00);
    tick(8);

    // Release all four: F0-prefixed breaks in index order.
    c = cyc;
    apply_stimulus(4'b0000, 1'b1);
    expect_byte(8'hF0, c + 1);  expect_byte(8'h5A, c + 2);
    expect_byte(8'hF0, c + 4);  expect_byte(8'h29, c + 5);
    expect_byte(8'hF0, c + 7);  expect_byte(8'h16, c + 8);
    expect_byte(8'hF0, c + 10); expect_byte(8'h1E, c + 11);
    tick(13);

    // Single press then release of Enter.
    c = cyc;
    apply_stimulus(4'b0001, 1'b1);
    expect_byte(8'h5A, c + 1);
    tick(1);
    check_output("press_ready", {7'd0, scan_code_ready}, 8'h01);
    check_output("press_code", scan_code, 8'h5A);
    tick(1);
    check_output("press_pulse_end", {7'd0, scan_code_ready}, 8'h00);
    check_output("press_busy", {7'd0, busy}, 8'h00);
    check_output("idle_code_held", scan_code, 8'h5A);
    tick(1);
    c = cyc;
    apply_stimulus(4'b0000, 1'b1);
    expect_byte(8'hF0, c + 1);
    expect_byte(8'h5A, c + 2);
    tick(3);
    check_output("release_busy", {7'd0, busy}, 8'h00);

    // Simultaneous Space and '1'.
    c = cyc;
    apply_stimulus(4'b0110, 1'b1);
    expect_byte(8'h29, c + 1);
    expect_byte(8'h16, c + 3);
    tick(2);
    check_output("simul_gap_busy", {7'd0, busy}, 8'h00);
    tick(2);
    c = cyc;
    apply_stimulus(4'b0010, 1'b1);
    expect_byte(8'hF0, c + 1);
    expect_byte(8'h16, c + 2);
    tick(4);

    // Backpressure on Space's F0, with Space re-pressed mid-event.
    c = cyc;
    apply_stimulus(4'b0000, 1'b0);
    expect_byte(8'hF0, c + 4);
    expect_byte(8'h29, c + 5);
    expect_byte(8'h29, c + 7);
    tick(1);
    check_output("bp_code_1", scan_code, 8'hF0);
    tick(1);
    apply_stimulus(4'b0010, 1'b0);
    check_output("bp_code_2", scan_code, 8'hF0);
    tick(1);
    check_output("bp_code_3", scan_code, 8'hF0);
    check_output("bp_ready_3", {7'd0, scan_code_ready}, 8'h01);
    tick(1);
    apply_stimulus(4'b0010, 1'b1);
    tick(5);
    c = cyc;
    apply_stimulus(4'b0000, 1'b1);
    expect_byte(8'hF0, c + 1);
    expect_byte(8'h29, c + 2);
    tick(4);

    // Hold Enter long enough for typematic repeats, then release.
    c = cyc;
    apply_stimulus(4'b0001, 1'b1);
    expect_byte(8'h5A, c + 1);
`ifdef SCANCODE_TYPEMATIC_EN
    expect_byte(8'h5A, c + 11);
    expect_byte(8'h5A, c + 15);
    expect_byte(8'h5A, c + 19);
`endif
    tick(20);
    apply_stimulus(4'b0000, 1'b1);
    expect_byte(8'hF0, c + 21);
    expect_byte(8'h5A, c + 22);
    tick(3);
    check_output("typematic_end_busy", {7'd0, busy}, 8'h00);
    tick(12);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d bytes outstanding expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
